fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pc_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//
// Program-counter and fetch-sequencing stage that sits just ahead of the
// control decoder. It drives the instruction-ROM address and runs the
// Start/Done program handshake. It also latches the branch-condition code
// written by sbf* instructions. For b instructions it checks the ALU status
// and picks the next PC: either PC+1 or the branch target.
//
// Parameters
//   PC_W      program counter / ROM address width
//   LAST_PC   address of the final program instruction; completing it ends
//             the run unless that instruction is a taken jump
//   FLAG_RST  value loaded into FlagReg on reset and on restart from DONE
//
// Ports
//   Clk           in   system clock, all state on the rising edge
//   Reset         in   asynchronous, active-high reset
//   Start         in   level request to (re)start the program at PC 0
//   Branch        in   decoder Branch output
//   FlagWrite     in   decoder FlagWrite output (sbf* instruction)
//   Flag          in   decoder condition code for sbf*
//   Zero          in   ALU result==0 for the current instruction
//   Negative      in   ALU result sign for the current instruction
//   BranchTarget  in   absolute jump target from the branch lookup table
//   Halt          in   early-termination request from decode
//   ProgCtr       out  current instruction address to the ROM
//   Done          out  program finished (DONE state)
//   Running       out  executing instructions (RUN state)
//   FlagReg       out  latched branch condition code
//   Taken         out  combinational: current instruction is a taken jump
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned LAST_PC  = 1023,
    parameter logic [2:0]  FLAG_RST = 3'b000
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Branch,
    input  logic            FlagWrite,
    input  logic [2:0]      Flag,
    input  logic            Zero,
    input  logic            Negative,
    input  logic [PC_W-1:0] BranchTarget,
    input  logic            Halt,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Done,
    output logic            Running,
    output logic [2:0]      FlagReg,
    output logic            Taken
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Branch condition codes held in FlagReg; 101..111 are never taken.
    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_LT = 3'b010;
    localparam logic [2:0] CC_LE = 3'b011;
    localparam logic [2:0] CC_JP = 3'b100;

    localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(LAST_PC);

    state_t          state;
    logic            is_jump;
    logic            is_flag_set;
    logic            cond_met;
    logic            at_last;
    logic [PC_W-1:0] pc_plus_one;

    // The decoder uses Branch for both b and sbf*. FlagWrite tells them apart.
    assign is_jump     = Branch & ~FlagWrite;
    assign is_flag_set = Branch &  FlagWrite;
    assign at_last     = (ProgCtr == LAST_ADDR);

    // Natural modulo-2^PC_W wrap: the last address plus one becomes 0.
    assign pc_plus_one = ProgCtr + PC_W'(1);

    // The condition is evaluated against the pre-edge FlagReg. An sbf* in
    // this cycle only affects the instructions that follow it.
    always_comb begin
        // NOTE: default assignment first so every path drives cond_met and no latch is inferred.
        cond_met = 1'b0;
        case (FlagReg)
            CC_NE:   cond_met = ~Zero;
            CC_EQ:   cond_met = Zero;
            CC_LT:   cond_met = Negative;
            CC_LE:   cond_met = Negative | Zero;
            CC_JP:   cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    // Decoder and ALU inputs mean nothing outside RUN, so Taken is gated here.
    assign Taken = (state == ST_RUN) & is_jump & cond_met;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
            state   <= ST_IDLE;
            ProgCtr <= '0;
            FlagReg <= FLAG_RST;
        end else begin
            case (state)
                ST_IDLE: begin
                    // FlagReg is deliberately kept here. Only a restart from
                    // DONE returns it to FLAG_RST.
                    ProgCtr <= '0;
                    if (Start) begin
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (is_flag_set) begin
                        FlagReg <= Flag;
                    end
                    // Halt takes priority over a taken jump in the same cycle.
                    // A taken jump at LAST_PC keeps the program running.
                    if (Halt) begin
                        state <= ST_DONE;
                    end else if (Taken) begin
                        ProgCtr <= BranchTarget;
                    end else if (at_last) begin
                        state <= ST_DONE;
                    end else begin
                        ProgCtr <= pc_plus_one;
                    end
                end

                ST_DONE: begin
                    if (Start) begin
                        state   <= ST_RUN;
                        ProgCtr <= '0;
                        FlagReg <= FLAG_RST;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Both status outputs decode directly from the state register.
    assign Running = (state == ST_RUN);
    assign Done    = (state == ST_DONE);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Three copies of fetch_pc_unit get the same input stream. They differ only
// in LAST_PC (5, 1023, 1000). A behavioural program model for each copy
// predicts the outputs, and the driver pushes each prediction into a
// per-copy queue. A separate monitor pops the queues on every falling edge
// and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

    localparam int N      = 3;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    typedef struct {
        int pc;
        int mode;
        int flag;
    } mdl_t;

    typedef struct {
        int pc;
        bit done;
        bit running;
        int flag;
        bit taken;
    } exp_t;

    typedef struct {
        bit       start;
        bit       branch;
        bit       fwrite;
        bit [2:0] flag;
        bit       zero;
        bit       neg;
        bit [9:0] target;
        bit       halt;
    } stim_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Branch;
    logic       FlagWrite;
    logic [2:0] Flag;
    logic       Zero;
    logic       Negative;
    logic [9:0] BranchTarget;
    logic       Halt;

    logic [9:0] pc_o    [N];
    logic       done_o  [N];
    logic       run_o   [N];
    logic [2:0] flag_o  [N];
    logic       taken_o [N];

    mdl_t m       [N];
    int   last_pc [N] = '{5, 1023, 1000};
    exp_t exp_q   [N][$];

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    fetch_pc_unit #(.PC_W(10), .LAST_PC(5), .FLAG_RST(3'b000)) u_last5 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch),
        .FlagWrite(FlagWrite), .Flag(Flag), .Zero(Zero), .Negative(Negative),
        .BranchTarget(BranchTarget), .Halt(Halt),
        .ProgCtr(pc_o[0]), .Done(done_o[0]), .Running(run_o[0]),
        .FlagReg(flag_o[0]), .Taken(taken_o[0])
    );

    fetch_pc_unit #(.PC_W(10), .LAST_PC(1023), .FLAG_RST(3'b000)) u_full (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch),
        .FlagWrite(FlagWrite), .Flag(Flag), .Zero(Zero), .Negative(Negative),
        .BranchTarget(BranchTarget), .Halt(Halt),
        .ProgCtr(pc_o[1]), .Done(done_o[1]), .Running(run_o[1]),
        .FlagReg(flag_o[1]), .Taken(taken_o[1])
    );

    fetch_pc_unit #(.PC_W(10), .LAST_PC(1000), .FLAG_RST(3'b000)) u_last1000 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch),
        .FlagWrite(FlagWrite), .Flag(Flag), .Zero(Zero), .Negative(Negative),
        .BranchTarget(BranchTarget), .Halt(Halt),
        .ProgCtr(pc_o[2]), .Done(done_o[2]), .Running(run_o[2]),
        .FlagReg(flag_o[2]), .Taken(taken_o[2])
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    always @(negedge Clk) begin
        for (int k = 0; k < N; k++) begin
            if (exp_q[k].size() > 0) begin
                exp_t e;
                e = exp_q[k].pop_front();
                check($sformatf("cfg%0d_pc", k),      int'(pc_o[k]),    e.pc);
                check($sformatf("cfg%0d_done", k),    int'(done_o[k]),  int'(e.done));
                check($sformatf("cfg%0d_running", k), int'(run_o[k]),   int'(e.running));
                check($sformatf("cfg%0d_flagreg", k), int'(flag_o[k]),  e.flag);
                check($sformatf("cfg%0d_taken", k),   int'(taken_o[k]), int'(e.taken));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: stimulus did not complete within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Branch condition table from the instruction set definition.
    function automatic bit cond_true(input int code, input bit z, input bit n);
        if (code == 4) return 1'b1;
        if (code > 4)  return 1'b0;
        if (code == 0) return !z;
        if (code == 1) return z;
        if (code == 2) return n;
        return n | z;
    endfunction

    function automatic exp_t predict(input int k, input stim_t s);
        exp_t e;
        e.pc      = m[k].pc;
        e.done    = (m[k].mode == M_DONE);
        e.running = (m[k].mode == M_RUN);
        e.flag    = m[k].flag;
        e.taken   = (m[k].mode == M_RUN) && s.branch && !s.fwrite &&
                    cond_true(m[k].flag, s.zero, s.neg);
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m[k].pc   = 0;
            m[k].mode = M_IDLE;
            m[k].flag = 0;
        end
    endtask

    task automatic advance(input int k, input stim_t s);
        bit tk;
        if (m[k].mode == M_RUN) begin
            tk = s.branch && !s.fwrite && cond_true(m[k].flag, s.zero, s.neg);
            if (s.branch && s.fwrite) m[k].flag = int'(s.flag);
            if (s.halt)                 m[k].mode = M_DONE;
            else if (tk)                m[k].pc = int'(s.target);
            else if (m[k].pc == last_pc[k]) m[k].mode = M_DONE;
            else                        m[k].pc = (m[k].pc + 1) % 1024;
        end else if (m[k].mode == M_IDLE) begin
            if (s.start) m[k].mode = M_RUN;
        end else begin
            if (s.start) begin
                m[k].mode = M_RUN;
                m[k].pc   = 0;
                m[k].flag = 0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    function automatic stim_t mk(input bit start, input bit branch, input bit fwrite,
                                 input int flag, input bit zero, input bit neg,
                                 input int target, input bit halt);
        stim_t s;
        s.start  = start;
        s.branch = branch;
        s.fwrite = fwrite;
        s.flag   = 3'(flag);
        s.zero   = zero;
        s.neg    = neg;
        s.target = 10'(target);
        s.halt   = halt;
        return s;
    endfunction

    // Called one time unit after a rising edge. Drives one cycle, queues the
    // prediction for the following falling edge, then steps the models.
    task automatic apply(input stim_t s);
        Start        = s.start;
        Branch       = s.branch;
        FlagWrite    = s.fwrite;
        Flag         = s.flag;
        Zero         = s.zero;
        Negative     = s.neg;
        BranchTarget = s.target;
        Halt         = s.halt;
        for (int k = 0; k < N; k++) exp_q[k].push_back(predict(k, s));
        @(posedge Clk);
        for (int k = 0; k < N; k++) advance(k, s);
        #1;
    endtask

    task automatic nop();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Asserts Reset between edges. The outputs must be back at reset values
    // by the next falling edge.
    task automatic reset_now();
        Start = 0; Branch = 0; FlagWrite = 0; Flag = 0;
        Zero = 0; Negative = 0; BranchTarget = 0; Halt = 0;
        Reset = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < N; k++) exp_q[k].push_back(predict(k, mk(0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    int codes [5] = '{0, 2, 3, 4, 6};

    initial begin
        Reset = 1'b1;
        Start = 0; Branch = 0; FlagWrite = 0; Flag = 0;
        Zero = 0; Negative = 0; BranchTarget = 0; Halt = 0;
        #1;
        model_reset();
        for (int k = 0; k < N; k++) exp_q[k].push_back(predict(k, mk(0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Straight-line run. The LAST_PC=5 copy reaches DONE and holds at 5.
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        repeat (8) nop();

        // Reset in the middle of a run at PC 37.
        for (int i = 0; i < 200 && m[1].pc != 37; i++) nop();
        reset_now();

        // Restart from IDLE. Set flag eq, then jump taken / not taken.
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 1, 1, 1, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 1, 0, 200, 0));
        apply(mk(0, 1, 0, 0, 0, 0, 300, 0));

        // Condition sweep over the Zero/Negative patterns 00, 01, 10.
        foreach (codes[c]) begin
            apply(mk(0, 1, 1, codes[c], 0, 0, 0, 0));
            for (int zn = 0; zn < 3; zn++) begin
                apply(mk(0, 1, 0, 0, zn[1], zn[0], 100 + $urandom_range(0, 99), 0));
            end
        end

        // Jump to 12. A Halt arrives together with a taken jump, then restart from DONE.
        apply(mk(0, 1, 1, 4, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 0, 0, 12, 0));
        apply(mk(0, 1, 0, 0, 0, 0, 50, 1));
        nop();
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        nop();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            apply(mk($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                     1'($urandom_range(0, 1)), $urandom_range(0, 7),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1023), $urandom_range(0, 49) == 0));
        end

        // Full-length run with no branches: the LAST_PC=1023 copy must stop, not wrap.
        reset_now();
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 1100 && m[1].mode == M_RUN; i++) nop();
        repeat (3) nop();

        // Restart from DONE and walk to 998. Set jp and jump to 1023, then step.
        // The LAST_PC=1000 copy wraps to 0. The LAST_PC=1023 copy finishes.
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 1100 && m[2].pc != 998; i++) nop();
        apply(mk(0, 1, 1, 4, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 0, 0, 1023, 0));
        repeat (4) nop();

        @(negedge Clk);
        #1;
        for (int k = 0; k < N; k++) check($sformatf("cfg%0d_queue_drained", k), exp_q[k].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
